// File: rtl/counter_sequencer.sv
// counter_sequencer: sequences an external WIDTH-bit counter (load, enable until terminal, finish or reload); one command in flight, cmd_ready only in IDLE.
// Command-to-done latency 3+(end-start) cycles; optional count prescaler is built only when COUNTER_SEQ_PRESCALER_EN is defined.
module counter_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             cmd_reload,
  input  logic             pause,
  input  logic             abort,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [7:0]       pass_count
`ifdef COUNTER_SEQ_PRESCALER_EN
  ,
  input  logic [PRESCALE_W-1:0] prescale
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic             reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       pass_q, pass_d;
  logic             accept;
  logic             term;
  logic             tick;
  logic             term_hit;

  if (WIDTH < 1 || PRESCALE_W < 1) begin : g_param_check
    $error("counter_sequencer: WIDTH and PRESCALE_W must be positive");
  end

  assign accept   = cmd_valid && (state_q == S_IDLE);
  assign term     = (cnt_value == end_q);
  // A terminal hit only counts when abort is not cancelling the command this cycle.
  assign term_hit = (state_q == S_RUN) && term && !abort;

`ifdef COUNTER_SEQ_PRESCALER_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] div_q, div_d;

  assign tick = (div_q == presc_q);

  always_comb begin
    presc_d = accept ? prescale : presc_q;
    div_d   = div_q;
    if (state_q != S_RUN) begin
      div_d = '0;
    end else if (!pause) begin
      div_d = tick ? '0 : div_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      div_q   <= '0;
    end else begin
      presc_q <= presc_d;
      div_q   <= div_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (term) begin
          state_d = reload_q ? S_LOAD : S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Enable stays combinational so the counter stops on the very cycle it shows the end value.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    cnt_load   = (state_q == S_LOAD) && !abort && !reset;
    cnt_enable = (state_q == S_RUN) && !pause && !term && tick && !abort && !reset;
    cnt_data   = start_q;
  end

  always_comb begin
    start_d  = start_q;
    end_d    = end_q;
    reload_d = reload_q;
    pass_d   = pass_q;
    if (accept) begin
      start_d  = cmd_start;
      end_d    = cmd_end;
      reload_d = cmd_reload;
      pass_d   = 8'd0;
    end else if (term_hit && (pass_q != 8'hFF)) begin
      pass_d = pass_q + 8'd1;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    wrap_d = (state_q == S_RUN) && (state_d == S_LOAD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q  <= '0;
      end_q    <= '0;
      reload_q <= 1'b0;
      pass_q   <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      start_q  <= start_d;
      end_q    <= end_d;
      reload_q <= reload_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wrap       = wrap_q;
  assign pass_count = pass_q;

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller that sequences the 8-bit programmable counter datapath by driving its load, enable and data-in inputs and watching its output. A requester issues one command (start value, terminal value, one-shot or auto-reload) over a valid/ready handshake. The block loads the counter, enables counting until the terminal value is reached, then either finishes or reloads. It sits between the host-side command source and the counter register.

## Interface
- WIDTH, 8, counter datapath width; all value ports are WIDTH bits.
- PRESCALE_W, 8, prescaler width; used only when COUNTER_SEQ_PRESCALER_EN is defined.

- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_start  in  WIDTH  value loaded into the counter.
- cmd_end  in  WIDTH  terminal value.
- cmd_reload  in  1  1 = auto-reload forever, 0 = one-shot.
- pause  in  1  level; freezes counting while high.
- abort  in  1  level; cancels the active command.
- cnt_load  out  1  to counter LOAD.
- cnt_enable  out  1  to counter ENABLE.
- cnt_data  out  WIDTH  to counter DATA_IN.
- cnt_value  in  WIDTH  from counter DATA_OUT.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a one-shot command completes.
- wrap  out  1  one-cycle pulse on each auto-reload.
- pass_count  out  8  number of terminal-value hits since the last command accept; saturates at 255.
- prescale  in  PRESCALE_W  count divider; present only with COUNTER_SEQ_PRESCALER_EN.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture cmd_start, cmd_end, cmd_reload (and prescale), clear pass_count, go to LOAD.
- LOAD:
  - cnt_load=1 and cnt_data=captured start for exactly one cycle.
  - Next state is RUN.
- RUN:
  - term = (cnt_value == captured end).
  - cnt_enable = RUN && !pause && !term && tick. This is combinational so the counter stops exactly on end.
  - On term: increment pass_count.
    - If reload: go to LOAD and pulse wrap.
    - Otherwise: go to DONE.
  - term is evaluated even while pause is high.
- DONE: pulse done for one cycle, then go to IDLE.
- cnt_data holds the captured start in every state. cnt_load=0 outside LOAD.
- Arithmetic is modulo 2^WIDTH:
  - If end < start, the counter wraps through 255→0 and continues to end.
  - If start == end, term is true on the first RUN cycle: one-shot goes straight to DONE; reload gives LOAD/RUN alternating, with wrap every 2 cycles.
- abort:
  - From LOAD, RUN or DONE, go to IDLE on the next edge. No done or wrap pulse that cycle; pass_count is not incremented.
  - cnt_enable and cnt_load are forced to 0 in the abort cycle.
  - Abort has priority over term.
  - Abort while in IDLE is ignored, and a command presented in the same cycle is still accepted.
- reset: state IDLE, cmd_ready=1 (combinational from state), cnt_load=0, cnt_enable=0, cnt_data=0, busy=0, done=0, wrap=0, pass_count=0, captured registers 0. Reset overrides all inputs, including mid-command.

## Timing
- Accept at edge 0 → LOAD during cycle 1. The counter holds start after edge 2; RUN starts in cycle 2.
- One-shot with start=3, end=5:
  - cnt_enable high in cycles 2 and 3.
  - Cycle 4: cnt_value=5, term true, cnt_enable low.
  - done pulses in cycle 5; IDLE and cmd_ready in cycle 6.
- Command-to-done latency = 3 + ((end − start) mod 256) cycles, with no pause and no prescaler.
- Reload:
  - wrap is high in the LOAD cycle that follows the term cycle.
  - Period is 2 + ((end − start) mod 256) cycles.
- done, wrap and busy are registered outputs. cnt_enable is combinational.

## Configuration
- COUNTER_SEQ_PRESCALER_EN:
  - Defined:
    - An internal PRESCALE_W divider clears on entry to RUN and holds while pause is high.
    - tick=1 once every (prescale+1) RUN cycles.
    - prescale is sampled at command accept; prescale=0 behaves as undivided.
  - Undefined: tick is tied to 1, the prescale port and divider are absent, and behaviour is exactly as described above.

## Test plan
- Reset, then one-shot start=3, end=5 → single cnt_load pulse with cnt_data=3; cnt_enable high in exactly 2 cycles; done in cycle 5; pass_count=1.
- One-shot start=250, end=2 → counter wraps 255→0; 8 enable cycles; done pulses once.
- Reload start=0, end=3 for 20 cycles → wrap every 5 cycles; pass_count increments each wrap; done never pulses.
- pause high for 4 cycles in mid-RUN with start=0, end=4 → done delayed by exactly 4 cycles; cnt_enable low throughout the pause.
- abort in the same cycle as term → no done, no pass_count increment, IDLE next cycle. reset asserted mid-RUN → all outputs 0 on the next cycle.
- With COUNTER_SEQ_PRESCALER_EN, prescale=2, start=0, end=2 → cnt_enable high once every 3 RUN cycles; done 6 cycles after the first RUN cycle plus 1.
